clk_div_multi: RTL

- Parametrised multi-channel clock divider; successor to the fixed divide-by-8 divider.
- Each of N_CH channels produces a registered divided clock `dclk` and a single-cycle `tick` clock-enable from one system clock.
- Each channel has a runtime-programmable divisor and an individual enable.
- Divisor updates take effect only at a period boundary, so dclk never glitches or produces a short period. Used to pace slow peripherals (UART, LED scan, FPGA test harness) from the core clock.

---
 rtl/clk_div_multi_pkg.sv | 7 +
 rtl/clk_div_ch.sv | 84 ++++++++
 rtl/clk_div_multi.sv | 59 +++++
 3 files changed

// File: rtl/clk_div_multi_pkg.sv
// Shared constants for the multi-channel clock divider.
package clk_div_multi_pkg;

    localparam int unsigned CLK_DIV_MIN     = 2;
    localparam int unsigned CLK_DIV_DEFAULT = 4;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, live and shadow divisor, registered dclk/tick.
module clk_div_ch
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             dclk,
    output logic             tick,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_active;
    logic             r_dclk;
    logic             r_tick;

    logic             w_wrap;
    logic             w_apply;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_half;

    assign w_wrap    = r_active && (r_cnt == (r_div - ONE));
    assign w_cnt_inc = r_cnt + ONE;
    assign w_half    = r_div >> 1;
    // Shadow only reaches the live divisor at a period boundary or while stopped.
    assign w_apply   = r_pending && (!en || w_wrap);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= DIV_RST;
            r_shadow  <= DIV_RST;
            r_pending <= 1'b0;
            r_active  <= 1'b0;
            r_dclk    <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (!en) begin
                r_cnt    <= '0;
                r_active <= 1'b0;
                r_dclk   <= 1'b0;
                r_tick   <= 1'b0;
            end else if (!r_active || w_wrap) begin
                r_active <= 1'b1;
                r_cnt    <= '0;
                r_dclk   <= 1'b1;
                r_tick   <= 1'b1;
            end else begin
                r_cnt  <= w_cnt_inc;
                r_dclk <= (w_cnt_inc < w_half);
                r_tick <= 1'b0;
            end

            if (w_apply) begin
                r_div <= r_shadow;
            end

            // A write on the apply edge becomes the next pending value.
            if (wr_en) begin
                r_shadow  <= wr_div;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign dclk = r_dclk;
    assign tick = r_tick;
    assign busy = r_pending;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: write decode, range check, and per-channel dividers.
module clk_div_multi
    import clk_div_multi_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = CLK_DIV_DEFAULT,
    parameter int unsigned CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             div_we,
    input  logic [CH_W-1:0]  div_ch,
    input  logic [CNT_W-1:0] div_in,
    output logic             div_err,
    output logic [N_CH-1:0]  dclk,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  busy
);

    localparam logic [CNT_W-1:0] DIV_MIN_L = CNT_W'(CLK_DIV_MIN);
    localparam logic [CH_W:0]    N_CH_L    = (CH_W + 1)'(N_CH);

    logic            r_div_err;
    logic            w_legal;
    logic [N_CH-1:0] w_we;

    assign w_legal = ({1'b0, div_ch} < N_CH_L) && (div_in >= DIV_MIN_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_err <= 1'b0;
        end else begin
            r_div_err <= div_we && !w_legal;
        end
    end

    assign div_err = r_div_err;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign w_we[i] = div_we && w_legal && (div_ch == CH_W'(i));

        clk_div_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en[i]),
            .wr_en  (w_we[i]),
            .wr_div (div_in),
            .dclk   (dclk[i]),
            .tick   (tick[i]),
            .busy   (busy[i])
        );
    end

endmodule
